// File: rtl/ias_cmd_sequencer.sv
// ias_cmd_sequencer: initiator for the IAS core command interface.
// Host commands are queued in a small FIFO, popped one at a time, held on
// the IAS bus for HOLD_CYCLES cycles and, for LOAD/ADD, the accumulator
// value is captured and returned on the response port.
// Optional feature macro: IAS_SEQ_CHECK_EN stores cmd_expect per entry and
// flags rsp_mismatch when the captured value differs from it.
//
// Handshake rule for both host ports: a transfer happens on the rising edge
// where valid and ready are both high; valid and its payload must be held
// stable until that edge, and ready may not depend on the same-cycle valid.
module ias_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_opcode,
  input  logic [DATA_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_expect,
  output logic [DATA_W-1:0] ias_opcode,
  output logic [DATA_W-1:0] ias_address,
  output logic [DATA_W-1:0] ias_data_in,
  input  logic [DATA_W-1:0] ias_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_mismatch,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  localparam logic [DATA_W-1:0] OP_LOAD = DATA_W'(1);
  localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_op   [DEPTH];
  logic [DATA_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop;

  logic [DATA_W-1:0] cmd_op_q, cmd_addr_q, cmd_data_q;
  logic [CNT_W-1:0]  hold_cnt;
  logic              hold_done;
  logic              has_result;
  logic              mismatch_q;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  // Ready is forced low while reset is asserted, not just after the first edge.
  assign cmd_ready = reset & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign has_result = (cmd_op_q == OP_LOAD) || (cmd_op_q == OP_ADD);

`ifdef IAS_SEQ_CHECK_EN
  logic [DATA_W-1:0] fifo_exp [DEPTH];
  logic [DATA_W-1:0] cmd_exp_q;

  // Expected-result storage travels with each queued command.
  always_ff @(posedge clk) begin
    if (push) fifo_exp[wr_ptr] <= cmd_expect;
  end

  // Expected value for the command currently owning the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cmd_exp_q <= '0;
    else if (pop) cmd_exp_q <= fifo_exp[rd_ptr];
  end

  // Comparison is taken at the same edge the result is captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       mismatch_q <= 1'b0;
    else if (hold_done && has_result) mismatch_q <= (ias_data_out != cmd_exp_q);
  end
`else
  logic unused_expect;
  assign unused_expect = ^cmd_expect;
  assign mismatch_q    = 1'b0;
`endif

  // FIFO payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= cmd_opcode;
      fifo_addr[wr_ptr] <= cmd_address;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: pop in IDLE, hold in ISSUE, wait for host in RESP.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    hold_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // Unknown opcodes are dropped here and never reach the bus.
          if (fifo_op[rd_ptr] <= OP_ADD) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hold_cnt == CNT_W'(HOLD_CYCLES-1)) begin
          hold_done = 1'b1;
          state_d   = has_result ? S_RESP : S_IDLE;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command register loaded on every pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_op_q   <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else if (pop) begin
      cmd_op_q   <= fifo_op[rd_ptr];
      cmd_addr_q <= fifo_addr[rd_ptr];
      cmd_data_q <= fifo_data[rd_ptr];
    end
  end

  // Hold counter runs only while the command owns the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                hold_cnt <= '0;
    else if (state_q != S_ISSUE || hold_done) hold_cnt <= '0;
    else                       hold_cnt <= hold_cnt + CNT_W'(1);
  end

  // Accumulator captured on the edge that ends the last hold cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       rsp_data <= '0;
    else if (hold_done && has_result) rsp_data <= ias_data_out;
  end

  // Bus is NOP outside ISSUE, so a reset drops it to NOP asynchronously.
  always_comb begin
    ias_opcode  = '0;
    ias_address = '0;
    ias_data_in = '0;
    if (state_q == S_ISSUE) begin
      ias_opcode  = cmd_op_q;
      ias_address = cmd_addr_q;
      ias_data_in = cmd_data_q;
    end
  end

  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_mismatch = rsp_valid & mismatch_q;
  assign busy         = (state_q != S_IDLE) || !empty;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ias_cmd_sequencer.sv
// tb_ias_cmd_sequencer: directed plus randomized bench for ias_cmd_sequencer.
// A cycle-level IAS core model sits on the bus; expected responses come from
// a transaction-level reference of the command set applied in queue order.
// Honours IAS_SEQ_CHECK_EN for the expected mismatch flag.
module tb_ias_cmd_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_opcode, cmd_address, cmd_data, cmd_expect;
  logic [W-1:0] ias_opcode, ias_address, ias_data_in, ias_data_out;
  logic         rsp_valid, rsp_ready, rsp_mismatch, busy;
  logic [W-1:0] rsp_data;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int rsp_mode = 1;      // 0: ready low, 1: ready high, 2: random
  int rsp_count = 0;
  logic last_mism = 1'b0;

  logic [W-1:0] exp_q[$];
  logic         expm_q[$];
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] ref_ac;

  ias_cmd_sequencer #(.DATA_W(W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_address(cmd_address),
    .cmd_data(cmd_data), .cmd_expect(cmd_expect),
    .ias_opcode(ias_opcode), .ias_address(ias_address),
    .ias_data_in(ias_data_in), .ias_data_out(ias_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mismatch(rsp_mismatch), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // IAS core model: executes on the second cycle a command is on the bus.
  logic [W-1:0] core_mem [256];
  logic [W-1:0] core_ac;
  int           core_phase;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) core_mem[i] <= '0;
      core_ac    <= '0;
      core_phase <= 0;
    end else if (ias_opcode != 0) begin
      if (core_phase == 1) begin
        case (ias_opcode)
          8'd1: core_ac <= core_mem[ias_address];
          8'd2: core_mem[ias_address] <= ias_data_in;
          8'd3: core_ac <= core_ac + core_mem[ias_address];
          default: ;
        endcase
      end
      core_phase <= core_phase + 1;
    end else begin
      core_phase <= 0;
    end
  end
  assign ias_data_out = core_ac;

  // Reference model of the command stream.
  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ref_ac = '0;
    exp_q.delete();
    expm_q.delete();
  endtask

  function automatic logic [W-1:0] ref_predict(input logic [W-1:0] op, input logic [W-1:0] a);
    if (op == 1) return ref_mem[a];
    if (op == 3) return ref_ac + ref_mem[a];
    return ref_ac;
  endfunction

  task automatic ref_apply(input logic [W-1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] d, input logic [W-1:0] e);
    if (op == 2) ref_mem[a] = d;
    else if (op == 1 || op == 3) begin
      ref_ac = ref_predict(op, a);
      exp_q.push_back(ref_ac);
`ifdef IAS_SEQ_CHECK_EN
      expm_q.push_back(ref_ac != e);
`else
      expm_q.push_back(1'b0);
`endif
    end
  endtask

  // Driver: present one command and hold it until accepted.
  task automatic push(input logic [W-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] e);
    logic accepted;
    accepted = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_address = a; cmd_data = d; cmd_expect = e;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    check("push_accept_timeout", accepted, 1'b1);
    if (accepted) ref_apply(op, a, d, e);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0) begin done = 1'b1; break; end
    end
    check("drain_timeout", done, 1'b1);
  endtask

  // Response ready driver.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Scoreboard, response-hold and bus-protocol monitor.
  int           run_len = 0;
  logic [W-1:0] run_op, run_addr, run_data;
  logic         prev_pending = 1'b0;
  logic [W-1:0] prev_data;
  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) check("rsp_hold", {rsp_valid, rsp_data}, {1'b1, prev_data});
      prev_pending = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        last_mism = rsp_mismatch;
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          check("rsp_data", rsp_data, exp_q.pop_front());
          check("rsp_mismatch", rsp_mismatch, expm_q.pop_front());
        end
      end
      if (ias_opcode != 0) begin
        check("bus_opcode_legal", ias_opcode <= 3, 1'b1);
        if (run_len > 0)
          check("bus_hold_stable", {ias_opcode, ias_address, ias_data_in}, {run_op, run_addr, run_data});
        else begin
          run_op = ias_opcode; run_addr = ias_address; run_data = ias_data_in;
        end
        run_len++;
      end else if (run_len > 0) begin
        check("bus_hold_len", run_len, HOLD);
        run_len = 0;
      end
    end
  end

  // Directed and random sequence.
  initial begin
    int n0;
    logic seen;
    logic [W-1:0] held;
    reset = 1'b0; cmd_valid = 1'b0;
    cmd_opcode = '0; cmd_address = '0; cmd_data = '0; cmd_expect = '0;
    ref_reset();
    repeat (2) @(negedge clk);
    check("reset_ias_opcode", ias_opcode, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_mismatch", rsp_mismatch, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_ready", cmd_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", cmd_ready, 1);

    // Reset in the middle of a STORE.
    push(8'd2, 8'd1, 8'd25, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ias_opcode == 8'd2) begin seen = 1'b1; break; end
    end
    check("store_issue_seen", seen, 1);
    reset = 1'b0;
    #1;
    check("abort_bus_nop", ias_opcode, 0);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    ref_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_busy", busy, 0);
    check("release_state", dbg_state, 0);

    // Basic program: two responses 25 and 75.
    n0 = rsp_count;
    push(8'd2, 8'd1, 8'd25, 8'd0);
    push(8'd2, 8'd2, 8'd50, 8'd0);
    push(8'd1, 8'd1, 8'd0, 8'd25);
    push(8'd3, 8'd2, 8'd0, 8'd75);
    push(8'd2, 8'd3, 8'd75, 8'd0);
    wait_drain();
    check("prog_rsp_count", rsp_count - n0, 2);
    check("core_mem3", core_mem[3], 8'd75);

    // Backpressure: response pending, FIFO fills.
    rsp_mode = 0;
    push(8'd1, 8'd1, 8'd0, 8'd25);
    push(8'd2, 8'd4, 8'd9, 8'd0);
    push(8'd2, 8'd5, 8'd7, 8'd0);
    push(8'd1, 8'd4, 8'd0, 8'd9);
    push(8'd3, 8'd5, 8'd0, 8'd16);
    @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("bp_rsp_seen", seen, 1);
    held = rsp_data;
    repeat (6) @(negedge clk);
    check("bp_rsp_held", {rsp_valid, rsp_data, cmd_ready}, {1'b1, held, 1'b0});
    check("bp_rsp_value", held, 8'd25);
    rsp_mode = 1;
    wait_drain();

    // Illegal opcode is discarded.
    n0 = rsp_count;
    push(8'd7, 8'd1, 8'd99, 8'd0);
    push(8'd1, 8'd1, 8'd0, 8'd25);
    wait_drain();
    check("illegal_rsp_count", rsp_count - n0, 1);

    // Expected-value comparison.
    push(8'd1, 8'd1, 8'd0, 8'd25);
    push(8'd3, 8'd2, 8'd0, 8'd75);
    wait_drain();
    check("expect_match", last_mism, 0);
    push(8'd1, 8'd1, 8'd0, 8'd25);
    push(8'd3, 8'd2, 8'd0, 8'd74);
    wait_drain();
`ifdef IAS_SEQ_CHECK_EN
    check("expect_differ", last_mism, 1);
`else
    check("expect_differ", last_mism, 0);
`endif

    // Random traffic with random host backpressure.
    rsp_mode = 2;
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] op, a, d, e;
      op = ($urandom_range(0, 9) == 0) ? W'($urandom_range(4, 255)) : W'($urandom_range(0, 3));
      a  = W'($urandom_range(0, 7));
      d  = W'($urandom_range(0, 255));
      e  = $urandom_range(0, 1) ? ref_predict(op, a) : W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(op, a, d, e);
    end
    wait_drain();
    rsp_mode = 1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
